// File: rtl/guess_scheduler.sv
// guess_scheduler: round-robin arbiter that feeds validated letter guesses,
// one at a time, into the hangman game-logic datapath and tracks its
// red_busy / game_rdy handshake.
module guess_scheduler #(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic                     clk,
  input  logic                     nRst,
  input  logic [NUM_PLAYERS-1:0]   req,
  input  logic [8*NUM_PLAYERS-1:0] req_letter,
  input  logic                     game_active,
  input  logic                     game_over,
  input  logic                     gameEnd,
  input  logic                     red_busy,
  input  logic                     game_rdy,
  output logic [7:0]               guess,
  output logic [NUM_PLAYERS-1:0]   ack,
  output logic [NUM_PLAYERS-1:0]   reject,
  output logic [25:0]              used,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int unsigned PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StIssue,
    StWaitRdy
  } state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        win_q, win_d;
  logic [7:0]           cand_q, cand_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [7:0]           guess_q, guess_d;
  logic [25:0]          used_q, used_d;
  logic [NUM_PLAYERS-1:0] ack_q, ack_d;
  logic [NUM_PLAYERS-1:0] reject_q, reject_d;
  logic                 timeout_q, timeout_d;

  logic                 pick_found;
  logic [PW-1:0]        pick_idx;
  logic [PW-1:0]        scan_idx;
  logic [7:0]           pick_letter;
  logic                 cand_in_range;
  logic [4:0]           letter_idx;
  logic                 cand_used;
  logic                 cand_valid;
  logic [NUM_PLAYERS-1:0] win_onehot;
  logic [PW-1:0]        next_ptr;

  // Cyclic offset from the round-robin pointer, wrapped to the player count.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int unsigned off);
    int unsigned s;
    s = (32'(base) + off) % NUM_PLAYERS;
    return PW'(s);
  endfunction

  // Pick the first pending requester at or after rr_ptr and mux its letter.
  always_comb begin
    pick_found  = 1'b0;
    pick_idx    = '0;
    scan_idx    = '0;
    pick_letter = 8'h00;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      scan_idx = wrap_add(rr_ptr_q, i);
      if (!pick_found && req[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      if (PW'(i) == pick_idx) begin
        pick_letter = req_letter[8*i +: 8];
      end
    end
  end

  // Candidate validity: upper-case ASCII letter not already evaluated.
  always_comb begin
    cand_in_range = (cand_q >= 8'h41) && (cand_q <= 8'h5A);
    // 'A' is 0x41, so the low five bits minus one give the alphabet index.
    letter_idx    = cand_q[4:0] - 5'd1;
    cand_used     = 1'b0;
    for (int unsigned k = 0; k < 26; k++) begin
      if ((letter_idx == 5'(k)) && used_q[k]) begin
        cand_used = 1'b1;
      end
    end
    cand_valid = cand_in_range && !cand_used;
  end

  // Decode the current winner and the pointer that follows it.
  always_comb begin
    win_onehot = '0;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      win_onehot[i] = (PW'(i) == win_q);
    end
    next_ptr = (win_q == PW'(NUM_PLAYERS - 1)) ? '0 : win_q + 1'b1;
  end

  // Next-state and registered-pulse logic; gameEnd overrides every state.
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    cand_d    = cand_q;
    rr_ptr_d  = rr_ptr_q;
    timer_d   = timer_q;
    guess_d   = guess_q;
    used_d    = used_q;
    ack_d     = '0;
    reject_d  = '0;
    timeout_d = 1'b0;

    if (gameEnd) begin
      state_d  = StIdle;
      used_d   = '0;
      guess_d  = 8'h00;
      rr_ptr_d = '0;
      timer_d  = '0;
      if (state_q != StIdle) begin
        reject_d = win_onehot;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (game_active && !game_over && !red_busy && pick_found) begin
            win_d   = pick_idx;
            cand_d  = pick_letter;
            state_d = StCheck;
          end
        end
        StCheck: begin
          if (!cand_valid) begin
            reject_d = win_onehot;
            rr_ptr_d = next_ptr;
            state_d  = StIdle;
          end else begin
            guess_d = cand_q;
            timer_d = '0;
            state_d = StIssue;
          end
        end
        StIssue: begin
          if (red_busy) begin
            state_d = StWaitRdy;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            // Game logic never picked the guess up; guess is left as-is.
            timeout_d = 1'b1;
            reject_d  = win_onehot;
            rr_ptr_d  = next_ptr;
            state_d   = StIdle;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        StWaitRdy: begin
          if (game_rdy) begin
            for (int unsigned k = 0; k < 26; k++) begin
              if (letter_idx == 5'(k)) begin
                used_d[k] = 1'b1;
              end
            end
            ack_d    = win_onehot;
            rr_ptr_d = next_ptr;
            state_d  = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q   <= StIdle;
      win_q     <= '0;
      cand_q    <= 8'h00;
      rr_ptr_q  <= '0;
      timer_q   <= '0;
      guess_q   <= 8'h00;
      used_q    <= '0;
      ack_q     <= '0;
      reject_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      cand_q    <= cand_d;
      rr_ptr_q  <= rr_ptr_d;
      timer_q   <= timer_d;
      guess_q   <= guess_d;
      used_q    <= used_d;
      ack_q     <= ack_d;
      reject_q  <= reject_d;
      timeout_q <= timeout_d;
    end
  end

  assign guess       = guess_q;
  assign used        = used_q;
  assign ack         = ack_q;
  assign reject      = reject_q;
  assign timeout_err = timeout_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_guess_scheduler.sv
// Directed self-checking bench for guess_scheduler (two players, TIMEOUT 16).
module tb_guess_scheduler;

  logic        clk;
  logic        nRst;
  logic [1:0]  req;
  logic [15:0] req_letter;
  logic        game_active;
  logic        game_over;
  logic        gameEnd;
  logic        red_busy;
  logic        game_rdy;
  logic [7:0]  guess;
  logic [1:0]  ack;
  logic [1:0]  reject;
  logic [25:0] used;
  logic        busy;
  logic        timeout_err;

  int checks;
  int errors;

  guess_scheduler #(
    .NUM_PLAYERS(2),
    .TIMEOUT    (16)
  ) dut (
    .clk        (clk),
    .nRst       (nRst),
    .req        (req),
    .req_letter (req_letter),
    .game_active(game_active),
    .game_over  (game_over),
    .gameEnd    (gameEnd),
    .red_busy   (red_busy),
    .game_rdy   (game_rdy),
    .guess      (guess),
    .ack        (ack),
    .reject     (reject),
    .used       (used),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  // From the negedge where a request was raised: CHECK, ISSUE, red_busy,
  // game_rdy; returns at the negedge where ack is visible.
  task automatic serve();
    tick();
    tick();
    red_busy = 1'b1;
    tick();
    red_busy = 1'b0;
    game_rdy = 1'b1;
    tick();
    game_rdy = 1'b0;
  endtask

  task automatic test_reset();
    nRst = 1'b0;
    tick();
    tick();
    checks++;
    if (guess !== 8'h00 || used !== 26'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state guess=%h used=%h busy=%b required 00/0/0", guess, used, busy);
    end
    checks++;
    if (ack !== 2'b00 || reject !== 2'b00 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses ack=%b reject=%b tmo=%b required 00/00/0", ack, reject,
               timeout_err);
    end
    nRst = 1'b1;
    tick();
  endtask

  task automatic test_accept();
    game_active = 1'b1;
    req_letter  = {8'h00, 8'h45};
    req         = 2'b01;
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL accept_busy_check busy=%b required 1", busy);
    end
    tick();
    checks++;
    if (guess !== 8'h45) begin
      errors++;
      $display("FAIL accept_guess guess=%h required 45", guess);
    end
    red_busy = 1'b1;
    tick();
    red_busy = 1'b0;
    game_rdy = 1'b1;
    tick();
    game_rdy = 1'b0;
    checks++;
    if (ack !== 2'b01 || reject !== 2'b00) begin
      errors++;
      $display("FAIL accept_ack ack=%b reject=%b required 01/00", ack, reject);
    end
    checks++;
    if (used !== 26'h10 || busy !== 1'b0) begin
      errors++;
      $display("FAIL accept_used used=%h busy=%b required 0000010/0", used, busy);
    end
    req = 2'b00;
    tick();
    checks++;
    if (ack !== 2'b00) begin
      errors++;
      $display("FAIL accept_ack_width ack=%b required 00", ack);
    end
  endtask

  task automatic test_duplicate();
    req_letter = {8'h00, 8'h45};
    req        = 2'b01;
    tick();
    tick();
    checks++;
    if (reject !== 2'b01 || ack !== 2'b00) begin
      errors++;
      $display("FAIL dup_reject reject=%b ack=%b required 01/00", reject, ack);
    end
    checks++;
    if (guess !== 8'h45 || used !== 26'h10) begin
      errors++;
      $display("FAIL dup_hold guess=%h used=%h required 45/0000010", guess, used);
    end
    req = 2'b00;
    tick();
    checks++;
    if (reject !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL dup_idle reject=%b busy=%b required 00/0", reject, busy);
    end
  endtask

  task automatic test_round_robin();
    // gameEnd in IDLE clears history and the pointer without a reject pulse.
    gameEnd = 1'b1;
    tick();
    gameEnd = 1'b0;
    checks++;
    if (used !== 26'h0 || guess !== 8'h00 || reject !== 2'b00) begin
      errors++;
      $display("FAIL rr_clear used=%h guess=%h reject=%b required 0/00/00", used, guess, reject);
    end
    req_letter = {8'h42, 8'h41};
    req        = 2'b11;
    serve();
    checks++;
    if (ack !== 2'b01 || guess !== 8'h41) begin
      errors++;
      $display("FAIL rr_first ack=%b guess=%h required 01/41", ack, guess);
    end
    req = 2'b10;
    serve();
    checks++;
    if (ack !== 2'b10 || guess !== 8'h42 || used !== 26'h3) begin
      errors++;
      $display("FAIL rr_second ack=%b guess=%h used=%h required 10/42/0000003", ack, guess, used);
    end
    req_letter = {8'h44, 8'h43};
    req        = 2'b11;
    serve();
    checks++;
    if (ack !== 2'b01 || guess !== 8'h43 || used !== 26'h7) begin
      errors++;
      $display("FAIL rr_third ack=%b guess=%h used=%h required 01/43/0000007", ack, guess, used);
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_bad_letter();
    logic [7:0] bad [4];
    bad[0] = 8'h61;
    bad[1] = 8'h00;
    bad[2] = 8'h40;
    bad[3] = 8'h5B;
    for (int i = 0; i < 4; i++) begin
      req_letter = {8'h00, bad[i]};
      req        = 2'b01;
      tick();
      tick();
      checks++;
      if (reject !== 2'b01 || guess !== 8'h43 || used !== 26'h7) begin
        errors++;
        $display("FAIL bad_letter_%h reject=%b guess=%h used=%h required 01/43/0000007", bad[i],
                 reject, guess, used);
      end
      req = 2'b00;
      tick();
    end
  endtask

  task automatic test_timeout();
    req_letter = {8'h00, 8'h5A};
    req        = 2'b01;
    tick();
    tick();
    checks++;
    if (guess !== 8'h5A) begin
      errors++;
      $display("FAIL tmo_guess guess=%h required 5a", guess);
    end
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (timeout_err !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL tmo_early cycle=%0d tmo=%b busy=%b required 0/1", i, timeout_err, busy);
      end
      tick();
    end
    tick();
    checks++;
    if (timeout_err !== 1'b1 || reject !== 2'b01) begin
      errors++;
      $display("FAIL tmo_pulse tmo=%b reject=%b required 1/01", timeout_err, reject);
    end
    checks++;
    if (busy !== 1'b0 || used[25] !== 1'b0 || guess !== 8'h5A) begin
      errors++;
      $display("FAIL tmo_after busy=%b used25=%b guess=%h required 0/0/5a", busy, used[25], guess);
    end
    req = 2'b00;
    tick();
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_width tmo=%b required 0", timeout_err);
    end
  endtask

  task automatic test_game_end();
    req_letter = {8'h00, 8'h51};
    req        = 2'b01;
    tick();
    tick();
    red_busy = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1 || guess !== 8'h51) begin
      errors++;
      $display("FAIL ge_wait busy=%b guess=%h required 1/51", busy, guess);
    end
    red_busy = 1'b0;
    gameEnd  = 1'b1;
    tick();
    gameEnd = 1'b0;
    checks++;
    if (reject !== 2'b01 || ack !== 2'b00) begin
      errors++;
      $display("FAIL ge_reject reject=%b ack=%b required 01/00", reject, ack);
    end
    checks++;
    if (guess !== 8'h00 || used !== 26'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ge_clear guess=%h used=%h busy=%b required 00/0/0", guess, used, busy);
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid();
    req_letter = {8'h00, 8'h4B};
    req        = 2'b01;
    serve();
    checks++;
    if (ack !== 2'b01 || used !== 26'h400) begin
      errors++;
      $display("FAIL rst_pre ack=%b used=%h required 01/0000400", ack, used);
    end
    req_letter = {8'h00, 8'h4D};
    tick();
    tick();
    checks++;
    if (guess !== 8'h4D || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_issue guess=%h busy=%b required 4d/1", guess, busy);
    end
    #2 nRst = 1'b0;
    #1;
    checks++;
    if (guess !== 8'h00 || used !== 26'h0 || busy !== 1'b0 || ack !== 2'b00 ||
        reject !== 2'b00 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_async guess=%h used=%h busy=%b ack=%b reject=%b tmo=%b required zeros",
               guess, used, busy, ack, reject, timeout_err);
    end
    req = 2'b00;
    tick();
    nRst = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || reject !== 2'b00) begin
      errors++;
      $display("FAIL rst_release busy=%b reject=%b required 0/00", busy, reject);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    nRst        = 1'b0;
    req         = 2'b00;
    req_letter  = 16'h0000;
    game_active = 1'b0;
    game_over   = 1'b0;
    gameEnd     = 1'b0;
    red_busy    = 1'b0;
    game_rdy    = 1'b0;
    test_reset();
    test_accept();
    test_duplicate();
    test_round_robin();
    test_bad_letter();
    test_timeout();
    test_game_end();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/guess_scheduler.md
# guess_scheduler

Arbitrates letter guesses from several wireless player receivers and feeds them one at a time into the hangman game-logic datapath. It round-robins among pending requesters and rejects letters that are non-alphabetic or already played. It drives a single held guess byte and tracks the game logic's busy/ready handshake to decide when each guess has been consumed. It sits between the UART/receiver front ends and the game-logic block.

## Interface
- NUM_PLAYERS, 2, number of requester ports (2–8)
- TIMEOUT, 16, cycles allowed between issuing a guess and seeing red_busy high
- clk  input  1  system clock, all state on rising edge
- nRst  input  1  asynchronous active-low reset
- req  input  NUM_PLAYERS  per-player level request, held until ack or reject
- req_letter  input  8*NUM_PLAYERS  ASCII guess; player i in bits [8i+7:8i], stable while req[i] high
- game_active  input  1  host has set the word and started play
- game_over  input  1  win/lose reached (red or green lit)
- gameEnd  input  1  new-game request; flushes scheduler
- red_busy  input  1  game logic is evaluating a guess
- game_rdy  input  1  game logic ready / evaluation complete pulse
- guess  output  8  held guess byte to game logic
- ack  output  NUM_PLAYERS  one-cycle pulse: guess accepted and evaluated
- reject  output  NUM_PLAYERS  one-cycle pulse: guess refused or aborted
- used  output  26  bit k set once letter 'A'+k has been evaluated
- busy  output  1  high in any state other than IDLE
- timeout_err  output  1  one-cycle pulse on handshake timeout

## Operation
- States: IDLE, CHECK, ISSUE, WAIT_RDY.
- IDLE: if game_active & !game_over & !red_busy & |req, select the first requester at or after rr_ptr (cyclic order). Register its index in win and its letter in cand, then go to CHECK. Otherwise stay in IDLE.
- CHECK: cand is invalid if it is outside 8'h41–8'h5A or used[cand-8'h41] is set. Invalid: reject[win] pulses, rr_ptr becomes win+1 (mod NUM_PLAYERS), go to IDLE. Valid: guess takes cand, timer clears, go to ISSUE.
- ISSUE: if red_busy, go to WAIT_RDY. Else if timer == TIMEOUT-1: timeout_err and reject[win] pulse, rr_ptr advances, guess is unchanged, go to IDLE. Else timer increments.
- WAIT_RDY: on game_rdy: used[cand-8'h41] is set, ack[win] pulses, rr_ptr becomes win+1, go to IDLE.
- gameEnd has priority in every state:
  - next state is IDLE;
  - used, guess, rr_ptr and timer all clear to 0;
  - if the state was not IDLE, reject[win] pulses.
- guess only changes in CHECK (valid letter) or on gameEnd/reset. A duplicate letter never reaches the game logic, because the game logic detects a new guess by a value change.
- At most one ack/reject bit is high in any cycle.
- Requests arriving while busy wait their turn; they are not lost.

## Timing
- Reset values: state IDLE, guess 8'h00, used 0, rr_ptr 0, timer 0, ack 0, reject 0, busy 0, timeout_err 0.
- ack, reject and timeout_err are registered and are high exactly one cycle.
- Request to reject for a bad letter: 2 cycles (IDLE→CHECK→IDLE). reject is visible in the cycle after CHECK.
- guess is valid in the cycle after CHECK and holds until the next valid CHECK or a clear.
- Accepted path: at least 3 cycles plus game-logic latency. ack appears the cycle after game_rdy is sampled in WAIT_RDY.
- A requester must drop req, or change letter, the cycle after its ack/reject. A req still high is re-arbitrated as a new request.
- Reset mid-operation: immediate asynchronous return to reset values. No ack/reject pulse is produced.
- game_over rising while in ISSUE or WAIT_RDY does not abort; the in-flight guess completes normally.

## Test plan
- Single player, game_active=1, req letter 8'h45 ('E'); drive red_busy 2 cycles later, then a game_rdy pulse → guess=8'h45, ack[0] one cycle, used[4]=1, busy returns to 0.
- Same letter 'E' requested again → reject[0] two cycles after req, guess stays 8'h45, red_busy never needed.
- Both players request simultaneously ('A','B') with rr_ptr=0 → player 0 served first, then player 1. A third simultaneous round serves player 0 first, since rr_ptr returns to 0 after player 1 is served.
- Letter 8'h61 ('a') or 8'h00 → reject, used unchanged, no guess change.
- Issue 'Z' and hold red_busy low for 16 cycles → timeout_err and reject[win] pulse together, state IDLE, used[25]=0.
- Assert gameEnd while in WAIT_RDY → reject[win] pulse, guess=0, used=0, busy=0 next cycle. Also pulse nRst low mid-ISSUE → all outputs at reset values asynchronously.
